// File: rtl/eject_arbiter_pkg.sv
// Shared defaults and helpers for the local ejection arbiter.
// Defaults can be overridden from the build with NUM_CHANNEL, EJECT_CNT_W and EJECT_STARVE_LIMIT.
`ifndef NUM_CHANNEL
`define NUM_CHANNEL 5
`endif

`ifndef EJECT_CNT_W
`define EJECT_CNT_W 16
`endif

`ifndef EJECT_STARVE_LIMIT
`define EJECT_STARVE_LIMIT 7
`endif

package eject_arbiter_pkg;

  localparam int DEF_NUM_CH       = `NUM_CHANNEL;
  localparam int DEF_CNT_W        = `EJECT_CNT_W;
  localparam int DEF_STARVE_LIMIT = `EJECT_STARVE_LIMIT;

  // Index width that never collapses to zero bits for tiny sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first request at or after ptr wins.
// Reusable by any port arbiter that keeps its own pointer register.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/eject_arbiter.sv
// Local ejection arbiter: one registered one-hot grant per cycle, losers flagged for deflection.
// Optional starvation override is enabled with the EJECT_STARVE_EN macro.
module eject_arbiter
  import eject_arbiter_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] eject_req,
  input  logic              local_ready,
  output logic [NUM_CH-1:0] localVector,
  output logic              local_valid,
  output logic [NUM_CH-1:0] deflect_vec,
  output logic [CNT_W-1:0]  eject_cnt
);

  localparam int PTR_W = idx_width(NUM_CH);

  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [NUM_CH-1:0] vec_reg, vec_next;
  logic              valid_reg, valid_next;
  logic [NUM_CH-1:0] defl_reg, defl_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [NUM_CH-1:0] rr_grant;
  logic [PTR_W-1:0]  rr_winner;
  logic              rr_any;

  logic [NUM_CH-1:0] win_onehot;
  logic [PTR_W-1:0]  win_idx;
  logic              grant_fire;

  rr_pick #(
    .N     (NUM_CH),
    .IDX_W (PTR_W)
  ) u_rr_pick (
    .req    (eject_req),
    .ptr    (ptr_reg),
    .grant  (rr_grant),
    .winner (rr_winner),
    .any    (rr_any)
  );

  assign grant_fire = local_ready && rr_any;

`ifdef EJECT_STARVE_EN
  localparam int AGE_W = idx_width(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0]  age_reg [NUM_CH];
  logic [NUM_CH-1:0] starve_vec;
  logic [NUM_CH-1:0] starve_onehot;
  logic [PTR_W-1:0]  starve_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_age
      assign starve_vec[gi] = eject_req[gi] && (age_reg[gi] >= AGE_MAX);

      // Age counts every lost request, blocked cycles included.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          age_reg[gi] <= '0;
        end else if (eject_req[gi]) begin
          if (grant_fire && win_onehot[gi]) begin
            age_reg[gi] <= '0;
          end else if (age_reg[gi] != AGE_MAX) begin
            age_reg[gi] <= age_reg[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    starve_onehot = '0;
    starve_idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (starve_vec[i]) begin
        starve_onehot    = '0;
        starve_onehot[i] = 1'b1;
        starve_idx       = PTR_W'(i);
      end
    end
  end

  assign win_onehot = (|starve_vec) ? starve_onehot : rr_grant;
  assign win_idx    = (|starve_vec) ? starve_idx    : rr_winner;
`else
  assign win_onehot = rr_grant;
  assign win_idx    = rr_winner;
`endif

  always_comb begin
    ptr_next   = ptr_reg;
    vec_next   = '0;
    valid_next = 1'b0;
    defl_next  = eject_req;
    cnt_next   = cnt_reg;
    if (grant_fire) begin
      vec_next   = win_onehot;
      valid_next = 1'b1;
      defl_next  = eject_req & ~win_onehot;
      ptr_next   = (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
      if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg   <= '0;
      vec_reg   <= '0;
      valid_reg <= 1'b0;
      defl_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      vec_reg   <= vec_next;
      valid_reg <= valid_next;
      defl_reg  <= defl_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign localVector = vec_reg;
  assign local_valid = valid_reg;
  assign deflect_vec = defl_reg;
  assign eject_cnt   = cnt_reg;

endmodule
